// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the pushbutton conditioner.
// Defaults assume a 50 MHz clock.
package btn_pkg;

  typedef enum logic [1:0] {
    UP        = 2'd0,
    WAIT_DOWN = 2'd1,
    DOWN      = 2'd2,
    WAIT_UP   = 2'd3
  } btn_state_t;

  localparam int DB_CYCLES_DEF     = 500000;
  localparam int LONG_CYCLES_DEF   = 100000000;
  localparam int REPEAT_DELAY_DEF  = 25000000;
  localparam int REPEAT_PERIOD_DEF = 5000000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, counter debouncer FSM, press/release pulses.
// Auto-repeat press pulses are built only when BTN_REPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
`ifdef BTN_REPEAT_EN
  , parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       key_n_i,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic [1:0] state_o
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync0_q, s_q;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d, press_any;
  logic          release_q, release_d;

  // Synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync0_q <= 1'b1;
      s_q     <= 1'b1;
    end else begin
      sync0_q <= key_n_i;
      s_q     <= sync0_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      UP: begin
        if (!s_q) begin
          state_d = WAIT_DOWN;
          cnt_d   = CW'(1);
        end
      end
      WAIT_DOWN: begin
        if (s_q) begin
          state_d = UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          cnt_d   = '0;
          level_d = 1'b0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN: begin
        if (s_q) begin
          state_d = WAIT_UP;
          cnt_d   = CW'(1);
        end
      end
      WAIT_UP: begin
        if (!s_q) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = UP;
          cnt_d     = '0;
          level_d   = 1'b1;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = UP;
        cnt_d   = '0;
        level_d = 1'b1;
      end
    endcase
  end

`ifdef BTN_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RW-1:0] rep_q, rep_d;
  logic          rep_fire;

  // Reloading to DELAY-PERIOD makes later pulses come every PERIOD cycles.
  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if (state_q == DOWN) begin
      if (rep_q == REP_LAST) begin
        rep_fire = 1'b1;
        rep_d    = REP_RELOAD;
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rep_q <= '0;
    else         rep_q <= rep_d;
  end

  assign press_any = press_d | rep_fire;
`else
  assign press_any = press_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= UP;
      cnt_q     <= '0;
      level_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_any;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign state_o   = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw active-low KEY pins: per-button debounce channels plus a
// long-press reset request on LONG_BTN. Auto-repeat is enabled by BTN_REPEAT_EN.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int LONG_BTN      = 0,
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [N_BTN-1:0] key_n_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o,
  output logic             reset_req_o
);

  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [N_BTN-1:0] LONG_MASK = N_BTN'(1) << LONG_BTN;

  if (DB_CYCLES < 2 || LONG_CYCLES < 2 || LONG_BTN >= N_BTN ||
      REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_params
    $error("button_conditioner: illegal parameter combination");
  end

  logic [N_BTN-1:0][1:0] ch_state;
  logic [N_BTN-1:0]      ch_down;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES     (DB_CYCLES)
`ifdef BTN_REPEAT_EN
      , .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk_i     (clk_clk),
      .rst_ni    (reset_reset_n),
      .key_n_i   (key_n_i[g]),
      .level_o   (btn_level_o[g]),
      .press_o   (btn_press_o[g]),
      .release_o (btn_release_o[g]),
      .state_o   (ch_state[g])
    );
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) ch_down[i] = (ch_state[i] == DOWN);
  end

  logic          hold_en;
  logic [HW-1:0] hold_q, hold_d;
  logic          done_q, done_d;
  logic          req_q, req_d;

  assign hold_en = |(ch_down & LONG_MASK);

  // hold_q saturates at its last value; done_q limits the request to one per press.
  always_comb begin
    hold_d = '0;
    done_d = 1'b0;
    req_d  = 1'b0;
    if (hold_en) begin
      done_d = done_q;
      if (hold_q != HOLD_LAST) begin
        hold_d = hold_q + 1'b1;
      end else begin
        hold_d = hold_q;
        if (!done_q) begin
          req_d  = 1'b1;
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hold_q <= '0;
      done_q <= 1'b0;
      req_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      done_q <= done_d;
      req_q  <= req_d;
    end
  end

  assign reset_req_o = req_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing parameters; cycle k of a
// window is the clock period following the k-th edge after the stimulus edge.
module tb_button_conditioner;

  localparam int N_BTN   = 4;
  localparam int DB      = 8;
  localparam int LONG    = 40;
  localparam int RDLY    = 20;
  localparam int RPER    = 6;
  localparam int WIN_MAX = 160;

  logic             clk_clk = 1'b0;
  logic             reset_reset_n = 1'b0;
  logic [N_BTN-1:0] key_n_i = '1;
  logic [N_BTN-1:0] btn_level_o, btn_press_o, btn_release_o;
  logic             reset_req_o;

  // clock / reset
  always #5 clk_clk = ~clk_clk;

  button_conditioner #(
    .N_BTN         (N_BTN),
    .DB_CYCLES     (DB),
    .LONG_BTN      (0),
    .LONG_CYCLES   (LONG),
    .REPEAT_DELAY  (RDLY),
    .REPEAT_PERIOD (RPER)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .key_n_i       (key_n_i),
    .btn_level_o   (btn_level_o),
    .btn_press_o   (btn_press_o),
    .btn_release_o (btn_release_o),
    .reset_req_o   (reset_req_o)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [N_BTN-1:0] key_s [WIN_MAX];
  logic             rst_s [WIN_MAX];
  logic [N_BTN-1:0] lvl_l [WIN_MAX];
  logic [N_BTN-1:0] prs_l [WIN_MAX];
  logic [N_BTN-1:0] rel_l [WIN_MAX];
  logic             req_l [WIN_MAX];

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // scoreboard
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // drivers
  task automatic sched_idle();
    for (int k = 0; k < WIN_MAX; k++) begin
      key_s[k] = '1;
      rst_s[k] = 1'b1;
    end
  endtask

  task automatic sched_key(input int b, input int from, input int to, input logic v);
    for (int k = from; k < to; k++) key_s[k][b] = v;
  endtask

  task automatic sched_rst(input int from, input int to);
    for (int k = from; k < to; k++) rst_s[k] = 1'b0;
  endtask

  // Entered #1 after a rising edge; leaves #1 after a rising edge.
  task automatic run_window(input int n);
    for (int k = 0; k < n; k++) begin
      key_n_i       = key_s[k];
      reset_reset_n = rst_s[k];
      @(negedge clk_clk);
      lvl_l[k] = btn_level_o;
      prs_l[k] = btn_press_o;
      rel_l[k] = btn_release_o;
      req_l[k] = reset_req_o;
      @(posedge clk_clk);
      #1;
    end
  endtask

  // kind: 0 press, 1 release, 2 reset request
  task automatic check_pulses(input string tag, input int kind, input int b, input int n);
    logic sig;
    int   m;
    got_q.delete();
    for (int k = 0; k < n; k++) begin
      case (kind)
        0:       sig = prs_l[k][b];
        1:       sig = rel_l[k][b];
        default: sig = req_l[k];
      endcase
      if (sig) got_q.push_back(8'(k));
    end
    check_val({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check_val($sformatf("%s cycle#%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  int cnt;

  initial begin
    // reset values
    repeat (3) @(posedge clk_clk);
    @(negedge clk_clk);
    check_val("rst level",   32'(btn_level_o),   32'hF);
    check_val("rst press",   32'(btn_press_o),   32'h0);
    check_val("rst release", 32'(btn_release_o), 32'h0);
    check_val("rst req",     32'(reset_req_o),   32'h0);
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    @(posedge clk_clk);
    #1;

    // clean press/release on key 1
    sched_idle();
    sched_key(1, 0, 30, 1'b0);
    run_window(50);
    exp_q.push_back(8'd10);
`ifdef BTN_REPEAT_EN
    exp_q.push_back(8'd30);
`endif
    check_pulses("t1 press", 0, 1, 50);
    exp_q.push_back(8'd40);
    check_pulses("t1 release", 1, 1, 50);
    check_pulses("t1 req", 2, 0, 50);
    check_val("t1 lvl@9",  32'(lvl_l[9][1]),  1);
    check_val("t1 lvl@10", 32'(lvl_l[10][1]), 0);
    check_val("t1 lvl@39", 32'(lvl_l[39][1]), 0);
    check_val("t1 lvl@40", 32'(lvl_l[40][1]), 1);
    cnt = 0;
    for (int k = 0; k < 50; k++) if (((prs_l[k] | rel_l[k]) & 4'b1101) != 0) cnt++;
    check_val("t1 other ch quiet", 32'(cnt), 0);

    // bounce on key 2: toggles every 3 cycles
    sched_idle();
    for (int k = 0; k < 30; k++) key_s[k][2] = ((k / 3) % 2) == 1;
    run_window(50);
    check_pulses("t2 bounce press", 0, 2, 50);
    check_pulses("t2 bounce release", 1, 2, 50);
    cnt = 0;
    for (int k = 0; k < 50; k++) if (!lvl_l[k][2]) cnt++;
    check_val("t2 bounce lvl low cycles", 32'(cnt), 0);

    // 7-cycle glitch is one short of acceptance
    sched_idle();
    sched_key(2, 0, 7, 1'b0);
    run_window(30);
    check_pulses("t2 glitch7 press", 0, 2, 30);
    check_pulses("t2 glitch7 release", 1, 2, 30);

    // 8-cycle low is just accepted
    sched_idle();
    sched_key(2, 0, 8, 1'b0);
    run_window(30);
    exp_q.push_back(8'd10);
    check_pulses("t2 low8 press", 0, 2, 30);
    exp_q.push_back(8'd18);
    check_pulses("t2 low8 release", 1, 2, 30);

    // simultaneous press on all keys
    sched_idle();
    for (int b = 0; b < N_BTN; b++) sched_key(b, 0, 25, 1'b0);
    run_window(45);
    check_val("t3 press@9",  32'(prs_l[9]),  32'h0);
    check_val("t3 press@10", 32'(prs_l[10]), 32'hF);
    check_val("t3 press@11", 32'(prs_l[11]), 32'h0);
    check_val("t3 lvl@10",   32'(lvl_l[10]), 32'h0);
    cnt = 0;
    for (int k = 0; k < 45; k++) if (prs_l[k] != 0) cnt++;
    check_val("t3 press cycles", 32'(cnt), 1);
    check_val("t3 release@35", 32'(rel_l[35]), 32'hF);
    check_val("t3 lvl@35",     32'(lvl_l[35]), 32'hF);
    check_pulses("t3 req", 2, 0, 45);

    // long press on key 0
    sched_idle();
    sched_key(0, 0, 100, 1'b0);
    run_window(125);
    exp_q.push_back(8'd50);
    check_pulses("t4 key0 req", 2, 0, 125);
    exp_q.push_back(8'd110);
    check_pulses("t4 key0 release", 1, 0, 125);

    // long hold on key 3 never requests reset
    sched_idle();
    sched_key(3, 0, 100, 1'b0);
    run_window(125);
    check_pulses("t4 key3 req", 2, 0, 125);
    exp_q.push_back(8'd110);
    check_pulses("t4 key3 release", 1, 3, 125);

    // auto-repeat window
    sched_idle();
    sched_key(1, 0, 50, 1'b0);
    run_window(70);
    exp_q.push_back(8'd10);
`ifdef BTN_REPEAT_EN
    exp_q.push_back(8'd30);
    exp_q.push_back(8'd36);
    exp_q.push_back(8'd42);
    exp_q.push_back(8'd48);
`endif
    check_pulses("t5 press", 0, 1, 70);
    exp_q.push_back(8'd60);
    check_pulses("t5 release", 1, 1, 70);

    // reset in the middle of WAIT_DOWN, key kept held
    sched_idle();
    sched_key(1, 0, 40, 1'b0);
    sched_rst(7, 10);
    run_window(55);
    check_val("t6 lvl@7",   32'(lvl_l[7]), 32'hF);
    check_val("t6 press@7", 32'(prs_l[7]), 32'h0);
    exp_q.push_back(8'd20);
`ifdef BTN_REPEAT_EN
    exp_q.push_back(8'd40);
`endif
    check_pulses("t6 press", 0, 1, 55);
    exp_q.push_back(8'd50);
    check_pulses("t6 release", 1, 1, 55);

    // reset while DOWN: level returns to 1 at once, no release pulse
    sched_idle();
    sched_key(1, 0, 40, 1'b0);
    sched_rst(15, 17);
    run_window(55);
    check_val("t7 lvl@14", 32'(lvl_l[14][1]), 0);
    check_val("t7 lvl@15", 32'(lvl_l[15][1]), 1);
    exp_q.push_back(8'd10);
    exp_q.push_back(8'd27);
    check_pulses("t7 press", 0, 1, 55);
    exp_q.push_back(8'd50);
    check_pulses("t7 release", 1, 1, 55);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
